// File: rtl/vga_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_pixel_gen
// Desc   : Two-stage test-pattern generator: bars, checker, bouncing box, solid.
//          Define PIXEL_GEN_BORDER_EN to force a white 1-px display border.
// Rev    : 1.0  initial release
// ============================================================================
module vga_pixel_gen #(
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [9:0]  xcol_i,
  input  logic [9:0]  yrow_i,
  input  logic        disp_active_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [1:0]  mode_i,
  input  logic [11:0] color_i,
  input  logic        freeze_i,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        disp_active_o
);

  localparam logic [1:0]  c_mode_bars    = 2'd0;
  localparam logic [1:0]  c_mode_checker = 2'd1;
  localparam logic [1:0]  c_mode_box     = 2'd2;
  localparam logic [10:0] c_x_max        = 11'(640 - BOX_SIZE);
  localparam logic [10:0] c_y_max        = 11'(480 - BOX_SIZE);
  localparam logic [10:0] c_step         = 11'(STEP);
  localparam logic [9:0]  c_step_10      = 10'(STEP);
  localparam logic [10:0] c_box          = 11'(BOX_SIZE);

  logic [9:0]  r_x1;
  logic [9:0]  r_y1;
  logic        r_de1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_vs_prev;
  logic [1:0]  r_mode;
  logic [11:0] r_color;
  logic [9:0]  r_box_x;
  logic [9:0]  r_box_y;
  logic        r_dir_x;
  logic        r_dir_y;

  logic        w_tick;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic [10:0] w_x_fwd;
  logic [10:0] w_y_fwd;
  logic [9:0]  w_x_bwd;
  logic [9:0]  w_y_bwd;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_box;
  logic [11:0] w_bar;
  logic [11:0] w_checker;
  logic [11:0] w_pattern;
  logic [11:0] w_pixel;

  // Stage 1: timing inputs, plus the previous stage-1 vsync for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x1      <= '0;
      r_y1      <= '0;
      r_de1     <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_x1      <= xcol_i;
      r_y1      <= yrow_i;
      r_de1     <= disp_active_i;
      r_hs1     <= hsync_i;
      r_vs1     <= vsync_i;
      r_vs_prev <= r_vs1;
    end
  end

  assign w_tick = r_vs1 & ~r_vs_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode  <= c_mode_bars;
      r_color <= 12'h000;
    end else if (w_tick) begin
      r_mode  <= mode_i;
      r_color <= color_i;
    end
  end

  assign w_x_ext = {1'b0, r_box_x};
  assign w_y_ext = {1'b0, r_box_y};
  assign w_x_fwd = w_x_ext + c_step;
  assign w_y_fwd = w_y_ext + c_step;
  assign w_x_bwd = r_box_x - c_step_10;
  assign w_y_bwd = r_box_y - c_step_10;

  // Box bounces off the edges by clamping to the limit and reversing direction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_tick && !freeze_i) begin
      if (r_dir_x) begin
        if (w_x_fwd >= c_x_max) begin
          r_box_x <= c_x_max[9:0];
          r_dir_x <= 1'b0;
        end else begin
          r_box_x <= w_x_fwd[9:0];
        end
      end else begin
        if (w_x_ext <= c_step) begin
          r_box_x <= '0;
          r_dir_x <= 1'b1;
        end else begin
          r_box_x <= w_x_bwd;
        end
      end
      if (r_dir_y) begin
        if (w_y_fwd >= c_y_max) begin
          r_box_y <= c_y_max[9:0];
          r_dir_y <= 1'b0;
        end else begin
          r_box_y <= w_y_fwd[9:0];
        end
      end else begin
        if (w_y_ext <= c_step) begin
          r_box_y <= '0;
          r_dir_y <= 1'b1;
        end else begin
          r_box_y <= w_y_bwd;
        end
      end
    end
  end

  always_comb begin
    w_bar = 12'h000;
    if      (r_x1 < 10'd80)  w_bar = 12'hFFF;
    else if (r_x1 < 10'd160) w_bar = 12'hFF0;
    else if (r_x1 < 10'd240) w_bar = 12'h0FF;
    else if (r_x1 < 10'd320) w_bar = 12'h0F0;
    else if (r_x1 < 10'd400) w_bar = 12'hF0F;
    else if (r_x1 < 10'd480) w_bar = 12'hF00;
    else if (r_x1 < 10'd560) w_bar = 12'h00F;
    else                     w_bar = 12'h000;
  end

  assign w_checker = (r_x1[5] ^ r_y1[5]) ? 12'hFFF : 12'h000;
  assign w_x_end   = w_x_ext + c_box;
  assign w_y_end   = w_y_ext + c_box;
  assign w_in_box  = (r_x1 >= r_box_x) && ({1'b0, r_x1} < w_x_end) &&
                     (r_y1 >= r_box_y) && ({1'b0, r_y1} < w_y_end);

  always_comb begin
    w_pattern = r_color;
    case (r_mode)
      c_mode_bars:    w_pattern = w_bar;
      c_mode_checker: w_pattern = w_checker;
      c_mode_box:     w_pattern = w_in_box ? 12'hF00 : 12'h00F;
      default:        w_pattern = r_color;
    endcase
  end

`ifdef PIXEL_GEN_BORDER_EN
  logic w_border;
  assign w_border = (r_x1 == 10'd0) || (r_x1 == 10'd639) ||
                    (r_y1 == 10'd0) || (r_y1 == 10'd479);
  assign w_pixel  = w_border ? 12'hFFF : w_pattern;
`else
  assign w_pixel  = w_pattern;
`endif

  // Stage 2: colour and the delayed timing signals leave together
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_o         <= 12'h000;
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      disp_active_o <= 1'b0;
    end else begin
      rgb_o         <= r_de1 ? w_pixel : 12'h000;
      hsync_o       <= r_hs1;
      vsync_o       <= r_vs1;
      disp_active_o <= r_de1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_gen.sv
`default_nettype none
// Scoreboard bench for vga_pixel_gen: a behavioural pattern/box model predicts
// every output pixel; a monitor compares on the falling edge.
module tb_vga_pixel_gen;

  localparam int BOX_SIZE = 32;
  localparam int STEP     = 2;
  localparam int XMAX     = 640 - BOX_SIZE;
  localparam int YMAX     = 480 - BOX_SIZE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  xcol_i = '0;
  logic [9:0]  yrow_i = '0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b1;
  logic        vs_i = 1'b1;
  logic [1:0]  mode_i = '0;
  logic [11:0] color_i = '0;
  logic        freeze_i = 1'b0;
  logic [11:0] rgb_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;

  always #5 clk = ~clk;

  vga_pixel_gen #(.BOX_SIZE(BOX_SIZE), .STEP(STEP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .xcol_i(xcol_i), .yrow_i(yrow_i),
    .disp_active_i(de_i), .hsync_i(hs_i), .vsync_i(vs_i), .mode_i(mode_i),
    .color_i(color_i), .freeze_i(freeze_i), .rgb_o(rgb_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .disp_active_o(de_o)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  int          m_mode;
  logic [11:0] m_color;
  int          bx, by;
  bit          dx, dy;
  bit          prev_vs, pending;
  int          cur_mode;
  logic [11:0] cur_color;
  bit          cur_frz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [11:0] bar_color(input int x);
    if (x >= 640) return 12'h000;
    case (x / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] ref_pixel(input int x, input int y, input bit de);
    logic [11:0] p;
    if (!de) return 12'h000;
    case (m_mode)
      0: p = bar_color(x);
      1: p = (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: p = (x >= bx && x < bx + BOX_SIZE && y >= by && y < by + BOX_SIZE) ? 12'hF00 : 12'h00F;
      default: p = m_color;
    endcase
`ifdef PIXEL_GEN_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) p = 12'hFFF;
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_color = 12'h000;
    bx = 0; by = 0; dx = 1; dy = 1;
    prev_vs = 1; pending = 0;
  endtask

  task automatic frame_update();
    m_mode  = cur_mode;
    m_color = cur_color;
    if (!cur_frz) begin
      if (dx) begin
        if (bx + STEP >= XMAX) begin bx = XMAX; dx = 0; end else bx = bx + STEP;
      end else begin
        if (bx <= STEP) begin bx = 0; dx = 1; end else bx = bx - STEP;
      end
      if (dy) begin
        if (by + STEP >= YMAX) begin by = YMAX; dy = 0; end else by = by + STEP;
      end else begin
        if (by <= STEP) begin by = 0; dy = 1; end else by = by - STEP;
      end
    end
  endtask

  // One input slot: the frame start seen last slot takes effect at this edge
  task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs);
    exp_t e;
    xcol_i = 10'(x); yrow_i = 10'(y); de_i = de; hs_i = hs; vs_i = vs;
    mode_i = 2'(cur_mode); color_i = cur_color; freeze_i = cur_frz;
    if (pending) frame_update();
    pending = vs && !prev_vs;
    prev_vs = vs;
    e.due = cyc + 2; e.rgb = ref_pixel(x, y, de); e.hs = hs; e.vs = vs; e.de = de;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic px(input int x, input int y, input bit de);
    if (x >= 0 && y >= 0) drive(x, y, de, 1'b1, 1'b1);
  endtask

  task automatic rand_px();
    int x, y;
    bit de;
    x  = int'($urandom_range(0, 799));
    y  = int'($urandom_range(0, 524));
    de = (x < 640 && y < 480) ? ($urandom_range(0, 7) != 0) : 1'b0;
    drive(x, y, de, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic frame(input int mode, input logic [11:0] color, input bit frz,
                       input int npix, input bit probes);
    cur_mode = mode; cur_color = color; cur_frz = frz;
    drive(700, 490, 1'b0, 1'b1, 1'b0);
    drive(700, 491, 1'b0, 1'b1, 1'b1);
    rand_px();
    if (probes) begin
      px(bx - 1, by, 1'b1);
      px(bx, by, 1'b1);
      px(bx + BOX_SIZE - 1, by + BOX_SIZE - 1, 1'b1);
      px(bx + BOX_SIZE, by, 1'b1);
      px(bx, by + BOX_SIZE, 1'b1);
      px(bx, by - 1, 1'b1);
      px(0, 100, 1'b1);
    end
    for (int i = 0; i < npix; i++) rand_px();
  endtask

  task automatic check_reset_outputs();
    chk("reset rgb", rgb_o, 12'h000);
    chk("reset hs/vs/de", {9'd0, hsync_o, vsync_o, de_o}, 12'b110);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          chk("missed slot", 12'h001, 12'h000);
        end else begin
          chk("rgb", rgb_o, e.rgb);
          chk("hs/vs/de", {9'd0, hsync_o, vsync_o, de_o}, {9'd0, e.hs, e.vs, e.de});
        end
      end
    end
  end

  initial begin
    model_reset();
    cur_mode = 0; cur_color = 12'h000; cur_frz = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    frame(0, 12'h000, 0, 6, 0);
    px(85, 10, 1'b1);
    px(639, 10, 1'b1);
    px(79, 300, 1'b1);
    px(80, 300, 1'b1);

    frame(3, 12'hF0F, 0, 4, 0);
    px(700, 10, 1'b0);
    px(5, 5, 1'b1);
    drive(20, 20, 1'b1, 1'b0, 1'b1);
    drive(21, 20, 1'b1, 1'b1, 1'b1);

    for (int f = 0; f < 16; f++)
      frame(int'($urandom_range(0, 3)), 12'($urandom), ($urandom_range(0, 3) == 0), 12, 1);

    frame(1, 12'h000, 0, 5, 0);
    cur_mode = 2;
    for (int i = 0; i < 10; i++) rand_px();
    px(bx, by, 1'b1);
    frame(2, 12'h000, 0, 4, 1);

    for (int f = 0; f < 3; f++) frame(2, 12'h000, 1, 2, 1);
    frame(2, 12'h000, 0, 2, 1);

    // asynchronous reset with non-reset outputs in flight
    frame(3, 12'h123, 0, 0, 0);
    px(100, 100, 1'b1);
    drive(101, 100, 1'b1, 1'b0, 1'b1);
    drive(102, 100, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    q.delete();
    model_reset();
    cur_mode = 0; cur_color = 12'h000; cur_frz = 0;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;

    // bounce run from the reset position, probing the box every frame
    for (int f = 0; f < 306; f++) frame(2, 12'h000, 0, 0, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      void'(q.pop_front());
      chk("unobserved slot", 12'h001, 12'h000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
